// File: rtl/rv32i_alu_pkg.sv
// Shared ALU definitions for the RV32I datapath: operation encodings and the
// default datapath width, also used by the control decoder.
package rv32i_alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

  // True for every op that needs a - b from the shared adder.
  function automatic logic op_subtracts(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/rv32i_alu_addsub.sv
// Single adder with optional B inversion and carry-in; provides sum, carry-out
// and signed overflow for ADD, SUB, SLT and SLTU.
module rv32i_alu_addsub #(
  parameter int WIDTH = rv32i_alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum   = full[WIDTH-1:0];
  assign cout  = full[WIDTH];

  // Overflow: both addends share a sign that the sum does not.
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/rv32i_alu.sv
// RV32I integer ALU: eight operations selected by ALUControl, with result and
// zero flag registered together for a fixed one-cycle latency.
module rv32i_alu #(
  parameter int WIDTH = rv32i_alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  import rv32i_alu_pkg::*;

  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             slt;
  logic             sltu;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] res_next;

  assign sub = op_subtracts(ALUControl);

  rv32i_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (srcA),
    .b    (srcB),
    .sub  (sub),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  // Signed less-than must survive overflow, so the difference sign is
  // corrected by the overflow bit; unsigned less-than is a missing carry.
  assign slt  = sum[WIDTH-1] ^ ovf;
  assign sltu = ~cout;
  assign shl  = srcA << srcB[4:0];

  always_comb begin
    res_next = '0;
    case (ALUControl)
      ALU_ADD:  res_next = sum;
      ALU_SUB:  res_next = sum;
      ALU_AND:  res_next = srcA & srcB;
      ALU_OR:   res_next = srcA | srcB;
      ALU_XOR:  res_next = srcA ^ srcB;
      ALU_SLT:  res_next = {{(WIDTH-1){1'b0}}, slt};
      ALU_SLTU: res_next = {{(WIDTH-1){1'b0}}, sltu};
      ALU_SLL:  res_next = shl;
      default:  res_next = '0;
    endcase
  end

  // zero comes from the same next-result value so res and zero never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res  <= '0;
      zero <= 1'b1;
    end else begin
      res  <= res_next;
      zero <= (res_next == '0);
    end
  end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed-vector bench for rv32i_alu: table of hand-computed results applied
// back to back, plus reset and latency sequences.
module tb_rv32i_alu;

  import rv32i_alu_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic [2:0]   ALUControl;
  logic [W-1:0] res;
  logic         zero;

  rv32i_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .srcA       (srcA),
    .srcB       (srcB),
    .ALUControl (ALUControl),
    .res        (res),
    .zero       (zero)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] r;
    logic         z;
    string        name;
  } vec_t;

  vec_t vecs[$];

  // Scoreboard
  int           n_vec = 0;
  int           n_err = 0;
  logic [W:0]   exp_q[$];
  string        name_q[$];

  task automatic compare(input string nm, input logic [W-1:0] exp_res,
                         input logic exp_zero);
    n_vec++;
    if (res !== exp_res || zero !== exp_zero) begin
      n_err++;
      $display("FAIL %s: got res=%h zero=%b, expected res=%h zero=%b",
               nm, res, zero, exp_res, exp_zero);
    end
  endtask

  task automatic check_pending();
    logic [W:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      compare(name_q.pop_front(), e[W-1:0], e[W]);
    end
  endtask

  // Driver: on each falling edge, check the result captured at the previous
  // rising edge, then present the next operands.
  task automatic drive(input vec_t v);
    @(negedge clk);
    check_pending();
    srcA       = v.a;
    srcB       = v.b;
    ALUControl = v.op;
    exp_q.push_back({v.z, v.r});
    name_q.push_back(v.name);
  endtask

  task automatic flush();
    @(negedge clk);
    check_pending();
  endtask

  task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic [W-1:0] r,
                         input logic z, input string nm);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.r = r; v.z = z; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec(32'd10, 32'd12, ALU_ADD,  32'h0000_0016, 1'b0, "sweep_add");
    add_vec(32'd10, 32'd12, ALU_SUB,  32'hFFFF_FFFE, 1'b0, "sweep_sub");
    add_vec(32'd10, 32'd12, ALU_AND,  32'h0000_0008, 1'b0, "sweep_and");
    add_vec(32'd10, 32'd12, ALU_OR,   32'h0000_000E, 1'b0, "sweep_or");
    add_vec(32'd10, 32'd12, ALU_XOR,  32'h0000_0006, 1'b0, "sweep_xor");
    add_vec(32'd10, 32'd12, ALU_SLT,  32'h0000_0001, 1'b0, "sweep_slt");
    add_vec(32'd10, 32'd12, ALU_SLTU, 32'h0000_0001, 1'b0, "sweep_sltu");
    add_vec(32'd10, 32'd12, ALU_SLL,  32'h0000_A000, 1'b0, "sweep_sll");
    add_vec(32'h1234_5678, 32'h1234_5678, ALU_SUB, 32'h0, 1'b1, "zero_sub_equal");
    add_vec(32'hFFFF_FFFF, 32'h1, ALU_ADD,  32'h0, 1'b1, "zero_add_wrap");
    add_vec(32'hFFFF_FFFF, 32'h1, ALU_SLT,  32'h1, 1'b0, "slt_neg1_lt_1");
    add_vec(32'hFFFF_FFFF, 32'h1, ALU_SLTU, 32'h0, 1'b1, "sltu_max_ge_1");
    add_vec(32'h8000_0000, 32'h1, ALU_SLT,  32'h1, 1'b0, "slt_min_ovf");
    add_vec(32'h8000_0000, 32'h1, ALU_SLTU, 32'h0, 1'b1, "sltu_msb_ge_1");
    add_vec(32'h1, 32'h8000_0000, ALU_SLT,  32'h0, 1'b1, "slt_1_vs_min");
    add_vec(32'h7FFF_FFFF, 32'hFFFF_FFFF, ALU_SLT, 32'h0, 1'b1, "slt_max_vs_neg1");
    add_vec(32'hFFFF_FFFE, 32'hFFFF_FFFF, ALU_SLT, 32'h1, 1'b0, "slt_neg2_lt_neg1");
    add_vec(32'h5, 32'h5, ALU_SLT,  32'h0, 1'b1, "slt_equal");
    add_vec(32'h5, 32'h5, ALU_SLTU, 32'h0, 1'b1, "sltu_equal");
    add_vec(32'h0, 32'hFFFF_FFFF, ALU_SLTU, 32'h1, 1'b0, "sltu_0_lt_max");
    add_vec(32'h1, 32'h0000_0025, ALU_SLL, 32'h0000_0020, 1'b0, "sll_mask_37");
    add_vec(32'h1, 32'd31, ALU_SLL, 32'h8000_0000, 1'b0, "sll_31");
    add_vec(32'hFFFF_FFFF, 32'hFFFF_FFE0, ALU_SLL, 32'hFFFF_FFFF, 1'b0, "sll_mask_0");
    add_vec(32'h0, 32'h1, ALU_SUB, 32'hFFFF_FFFF, 1'b0, "sub_borrow");
    add_vec(32'h7FFF_FFFF, 32'h1, ALU_ADD, 32'h8000_0000, 1'b0, "add_signed_ovf");
    add_vec(32'hFFFF_0000, 32'h0F0F_0F0F, ALU_AND, 32'h0F0F_0000, 1'b0, "and_mask");
    add_vec(32'h0, 32'h0, ALU_OR, 32'h0, 1'b1, "or_zero");
    add_vec(32'hA5A5_A5A5, 32'hA5A5_A5A5, ALU_XOR, 32'h0, 1'b1, "xor_self");

    // Reset asserted between edges takes effect immediately and holds.
    reset      = 1'b0;
    srcA       = 32'd10;
    srcB       = 32'd12;
    ALUControl = ALU_ADD;
    #2 reset = 1'b1;
    #1 compare("reset_immediate", 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1 compare("reset_hold_2_edges", 32'h0, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back vectors: every result must land exactly one edge later.
    foreach (vecs[i]) drive(vecs[i]);
    flush();

    // Asynchronous reset pulse mid-cycle discards the registered result.
    srcA       = 32'd10;
    srcB       = 32'd12;
    ALUControl = ALU_XOR;
    @(posedge clk);
    #1 compare("pre_reset_xor", 32'h0000_0006, 1'b0);
    #1 reset = 1'b1;
    #1 compare("async_reset_mid_cycle", 32'h0, 1'b1);
    ALUControl = ALU_OR;
    #1 reset = 1'b0;
    @(negedge clk);
    compare("reset_held_until_edge", 32'h0, 1'b1);
    @(negedge clk);
    compare("first_edge_after_reset", 32'h0000_000E, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv32i_alu.md
Name: rv32i_alu

Overview:
- 32-bit integer ALU for the RV32I datapath. Evaluates one of eight operations on srcA/srcB, selected by a 3-bit ALUControl.
- Result and zero flag are registered at the ALU output, giving one-cycle latency.
- Sits between the register-file/immediate operand muxes and the writeback/branch-compare logic.

Parameters:
- WIDTH, 32, operand and result width (the shift amount is always the low 5 bits of srcB).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- srcA  input  WIDTH  operand A
- srcB  input  WIDTH  operand B, also the shift amount source
- ALUControl  input  3  operation select
- res  output  WIDTH  registered result
- zero  output  1  registered flag, 1 when res is all zeros

Behaviour:
- Operation encoding (ALUControl):
  - 000 ADD: srcA + srcB, modulo 2^WIDTH.
  - 001 SUB: srcA - srcB, modulo 2^WIDTH.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: res = 1 if signed srcA < signed srcB, else 0; upper bits are 0.
  - 110 SLTU: same as SLT but unsigned compare.
  - 111 SLL: srcA << srcB[4:0]; upper bits of srcB are ignored; zeros are shifted in.
- All encodings are defined, so there is no illegal-op case.
- Latency:
  - The next result is computed combinationally from the current inputs.
  - res and zero load together on every rising clk edge, always enabled.
  - Outputs reflect the inputs sampled at the previous rising edge.
- zero is registered as (next result == 0). It is never derived from the already-registered res, so res and zero are always mutually consistent in the same cycle.
- Overflow and carry are discarded; ADD/SUB wrap.
- SLT must be correct across overflow. Compute it via sign comparison (or the sign of the subtraction XOR its overflow), not the raw subtraction sign. Example: srcA=0x80000000, srcB=1 gives res=1.
- Reset:
  - When reset asserts, res=0 and zero=1 immediately, independent of clk.
  - Outputs hold these values while reset is high.
  - The first capture occurs on the first rising clk edge after reset deasserts.
  - Reset asserted mid-operation discards the pending result.
- Simultaneous input change and clock edge: inputs must be stable for setup time. The value present at the edge is captured.
- No X propagation from the op mux: every ALUControl value selects a defined result.

Decomposition:
- Shared package rv32i_alu_pkg:
  - 3-bit ALUControl localparams ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL.
  - WIDTH default constant.
  - These are shared with the control decoder.
- One sub-module, rv32i_alu_addsub: a single adder with invert-B and carry-in. It outputs sum, carry-out and signed overflow, and is shared by ADD, SUB, SLT and SLTU.
- Logic ops, shifter, result mux and output register stay in rv32i_alu.

Test Plan (srcA=10, srcB=12 unless noted; check one clk after apply):
- Reset: assert reset between edges → res=0x00000000 and zero=1 immediately. Hold across 2 clk edges → unchanged.
- Sweep ALUControl 000..111 with 10/12:
  - ADD → 0x00000016, zero=0
  - SUB → 0xFFFFFFFE
  - AND → 0x00000008
  - OR → 0x0000000E
  - XOR → 0x00000006
  - SLT → 0x00000001
  - SLTU → 0x00000001
  - SLL → 0x0000A000
- Zero flag: SUB with srcA=srcB=0x12345678 → res=0, zero=1. ADD with 0xFFFFFFFF + 1 → res=0, zero=1 (wrap).
- Signed vs unsigned compare: srcA=0xFFFFFFFF, srcB=1 → SLT=1, SLTU=0. srcA=0x80000000, srcB=1 → SLT=1.
- Shift masking: SLL with srcA=1, srcB=0x00000025 → 0x00000020 (amount 5). srcB=31 → 0x80000000.
- Latency/reset mid-run: change ops every cycle and confirm each result appears exactly one edge later. Pulse reset asynchronously mid-cycle → outputs go to 0/1 at once, and the next post-reset edge shows the current inputs' result.
